// File: rtl/maxpool2d.sv
// maxpool2d: non-overlapping POOL x POOL signed max-pooling over a flat,
// multi-channel feature map, with an optional fused ReLU. One input element
// is read per cycle; each window costs POOL*POOL SCAN cycles plus one WRITE.
//
// Ports
//   clk                 single clock, rising edge
//   reset               asynchronous, active-low reset
//   start               begin one full pass (sampled only in IDLE)
//   input_feature_flat  CHANNELS*IMG_SIZE*IMG_SIZE signed words,
//                       index (ch*IMG_SIZE+row)*IMG_SIZE+col
//   out_feature_flat    CHANNELS*OUT_SIZE*OUT_SIZE signed words, same order
//   busy                high from the cycle after start through FINISH
//   done                one-cycle completion pulse
module maxpool2d #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IMG_SIZE   = 28,
    parameter int POOL       = 2,
    parameter int RELU       = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic [DATA_WIDTH*CHANNELS*IMG_SIZE*IMG_SIZE-1:0] input_feature_flat,
    output logic [DATA_WIDTH*CHANNELS*(IMG_SIZE/POOL)*(IMG_SIZE/POOL)-1:0] out_feature_flat,
    output logic busy,
    output logic done
);

    localparam int OUT_SIZE = IMG_SIZE / POOL;
    localparam int OUT_BITS = DATA_WIDTH * CHANNELS * OUT_SIZE * OUT_SIZE;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int OW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int PW = (POOL > 1) ? $clog2(POOL) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, WRITE, FINISH} state_t;

    state_t                  state;
    logic [CW-1:0]           ch;
    logic [OW-1:0]           orow;
    logic [OW-1:0]           ocol;
    logic [PW-1:0]           pr;
    logic [PW-1:0]           pc;
    logic signed [DATA_WIDTH-1:0] cur_max;

    logic [31:0]             in_idx;
    logic [31:0]             out_idx;
    logic signed [DATA_WIDTH-1:0] elem;
    logic [DATA_WIDTH-1:0]   res;
    logic [OUT_BITS-1:0]     wr_mask;
    logic [OUT_BITS-1:0]     wr_data;

    // Element selection and output word placement are done with shifts so
    // a single datapath serves every window position.
    // NOTE: every always_comb output gets a default first, so no latch can form.
    always_comb begin
        in_idx  = (32'(ch) * IMG_SIZE + 32'(orow) * POOL + 32'(pr)) * IMG_SIZE
                + 32'(ocol) * POOL + 32'(pc);
        out_idx = (32'(ch) * OUT_SIZE + 32'(orow)) * OUT_SIZE + 32'(ocol);
        elem    = DATA_WIDTH'(input_feature_flat >> (in_idx * DATA_WIDTH));
        res     = cur_max;
        if (RELU != 0 && cur_max[DATA_WIDTH-1])
            res = '0;
        wr_mask = OUT_BITS'({DATA_WIDTH{1'b1}}) << (out_idx * DATA_WIDTH);
        wr_data = OUT_BITS'(res) << (out_idx * DATA_WIDTH);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            ch      <= '0;
            orow    <= '0;
            ocol    <= '0;
            pr      <= '0;
            pc      <= '0;
            cur_max <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ch    <= '0;
                        orow  <= '0;
                        ocol  <= '0;
                        pr    <= '0;
                        pc    <= '0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    // First element of a window seeds the max; ties keep it.
                    if (pr == '0 && pc == '0)
                        cur_max <= elem;
                    else if (elem > cur_max)
                        cur_max <= elem;
                    if (pc == PW'(POOL - 1)) begin
                        pc <= '0;
                        if (pr == PW'(POOL - 1)) begin
                            pr    <= '0;
                            state <= WRITE;
                        end else begin
                            pr <= pr + 1'b1;
                        end
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                WRITE: begin
                    pr    <= '0;
                    pc    <= '0;
                    state <= SCAN;
                    if (ocol == OW'(OUT_SIZE - 1)) begin
                        ocol <= '0;
                        if (orow == OW'(OUT_SIZE - 1)) begin
                            orow <= '0;
                            if (ch == CW'(CHANNELS - 1)) begin
                                ch    <= '0;
                                state <= FINISH;
                            end else begin
                                ch <= ch + 1'b1;
                            end
                        end else begin
                            orow <= orow + 1'b1;
                        end
                    end else begin
                        ocol <= ocol + 1'b1;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output map: only the word addressed by the current window changes, and
    // only on its WRITE edge.
    // NOTE: this wide register array is deliberately reset, because the output
    // map must read all zeros while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            out_feature_flat <= '0;
        else if (state == WRITE)
            out_feature_flat <= (out_feature_flat & ~wr_mask) | wr_data;
    end

endmodule

// File: tb/tb_maxpool2d.sv
// Self-checking bench for maxpool2d: table-driven 2x2 windows (ReLU on/off),
// an odd-size map, and full default-size passes with stray starts and a
// mid-pass asynchronous reset.
module tb_maxpool2d;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    // Default-parameter instance.
    logic               big_start;
    logic [16*6272-1:0] big_in;
    logic [16*1568-1:0] big_out;
    logic               big_busy, big_done;

    // 2x2 single-channel instances, RELU off and on, sharing stimulus.
    logic               sm_start;
    logic [63:0]        sm_in;
    logic [15:0]        sm_out0, sm_out1;
    logic               sm_busy0, sm_done0, sm_busy1, sm_done1;

    // 5x5 single-channel instance.
    logic               od_start;
    logic [16*25-1:0]   od_in;
    logic [16*4-1:0]    od_out;
    logic               od_busy, od_done;

    maxpool2d u_big (
        .clk(clk), .reset(reset), .start(big_start),
        .input_feature_flat(big_in), .out_feature_flat(big_out),
        .busy(big_busy), .done(big_done)
    );

    maxpool2d #(.CHANNELS(1), .IMG_SIZE(2), .RELU(0)) u_sm0 (
        .clk(clk), .reset(reset), .start(sm_start),
        .input_feature_flat(sm_in), .out_feature_flat(sm_out0),
        .busy(sm_busy0), .done(sm_done0)
    );

    maxpool2d #(.CHANNELS(1), .IMG_SIZE(2), .RELU(1)) u_sm1 (
        .clk(clk), .reset(reset), .start(sm_start),
        .input_feature_flat(sm_in), .out_feature_flat(sm_out1),
        .busy(sm_busy1), .done(sm_done1)
    );

    maxpool2d #(.CHANNELS(1), .IMG_SIZE(5), .RELU(0)) u_odd (
        .clk(clk), .reset(reset), .start(od_start),
        .input_feature_flat(od_in), .out_feature_flat(od_out),
        .busy(od_busy), .done(od_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w [4];   // (0,0), (0,1), (1,0), (1,1)
        logic [15:0] exp_norelu;
        logic [15:0] exp_relu;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Every pooled word of a ramp input is the bottom-right element of its window.
    task automatic check_ramp(input string tag);
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 14; r++)
                for (int k = 0; k < 14; k++) begin
                    int o, i;
                    o = (c * 14 + r) * 14 + k;
                    i = (c * 28 + 2 * r + 1) * 28 + 2 * k + 1;
                    check($sformatf("%s_out[%0d]", tag, o), 32'(big_out[o*16 +: 16]), 32'(i % 32768));
                end
    endtask

    // Run one default pass. pulses: raise start again before E100 and E500.
    // abort_at > 0: assert reset asynchronously just after that edge.
    task automatic run_big(input string tag, input bit pulses, input int abort_at);
        int done_edge;
        int busy_err;
        done_edge = -1;
        busy_err  = 0;
        @(negedge clk) big_start = 1'b1;
        @(posedge clk);
        #1 big_start = 1'b0;
        if (big_busy !== 1'b1) busy_err++;
        for (int e = 1; e <= 9000; e++) begin
            big_start = pulses && (e == 100 || e == 500);
            @(posedge clk);
            #1;
            if (e == abort_at) begin
                #2 reset = 1'b0;
                #1;
                check({tag, "_abort_done"}, 32'(big_done), 32'd0);
                check({tag, "_abort_busy"}, 32'(big_busy), 32'd0);
                check({tag, "_abort_out_zero"}, 32'(big_out == '0), 32'd1);
                repeat (3) @(posedge clk);
                @(negedge clk) reset = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                check({tag, "_stays_idle"}, 32'({big_busy, big_done}), 32'd0);
                check({tag, "_busy_before_abort"}, 32'(busy_err), 32'd0);
                return;
            end
            if (big_done === 1'b1) begin
                done_edge = e;
                break;
            end
            if (big_busy !== 1'b1) busy_err++;
        end
        big_start = 1'b0;
        check({tag, "_done_edge"}, 32'(done_edge), 32'd7841);
        check({tag, "_busy_through_pass"}, 32'(busy_err), 32'd0);
        check({tag, "_busy_low_at_done"}, 32'(big_busy), 32'd0);
        @(posedge clk);
        #1 check({tag, "_done_one_cycle"}, 32'(big_done), 32'd0);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b0;
        big_start = 1'b0;
        sm_start  = 1'b0;
        od_start  = 1'b0;
        sm_in     = '0;
        for (int i = 0; i < 6272; i++)
            big_in[i*16 +: 16] = 16'(i % 32768);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                od_in[(r*5+c)*16 +: 16] = (r == 4 || c == 4) ? 16'h7000 : 16'h0001;

        vecs[0] = '{w: '{16'hFFFB, 16'hFFFD, 16'hFFF8, 16'hFFFC}, exp_norelu: 16'hFFFD, exp_relu: 16'h0000};
        vecs[1] = '{w: '{16'h8000, 16'h8000, 16'h8000, 16'h7FFF}, exp_norelu: 16'h7FFF, exp_relu: 16'h7FFF};
        vecs[2] = '{w: '{16'h8000, 16'h8000, 16'h8000, 16'h8000}, exp_norelu: 16'h8000, exp_relu: 16'h0000};
        vecs[3] = '{w: '{16'h0005, 16'h0009, 16'h0009, 16'h0002}, exp_norelu: 16'h0009, exp_relu: 16'h0009};
        vecs[4] = '{w: '{16'h0001, 16'h0002, 16'h0003, 16'h0004}, exp_norelu: 16'h0004, exp_relu: 16'h0004};
        vecs[5] = '{w: '{16'h7FFF, 16'h0000, 16'hFFFF, 16'h7FFF}, exp_norelu: 16'h7FFF, exp_relu: 16'h7FFF};
        vecs[6] = '{w: '{16'hFFFF, 16'h8001, 16'hFFFF, 16'hFFFE}, exp_norelu: 16'hFFFF, exp_relu: 16'h0000};
        vecs[7] = '{w: '{16'h0000, 16'hFFFF, 16'h8000, 16'h0000}, exp_norelu: 16'h0000, exp_relu: 16'h0000};

        // Reset state, sampled while reset is still held.
        #12;
        check("rst_big_busy_done", 32'({big_busy, big_done}), 32'd0);
        check("rst_big_out_zero", 32'(big_out == '0), 32'd1);
        check("rst_sm_out", 32'({sm_out0, sm_out1}), 32'd0);
        check("rst_sm_busy_done", 32'({sm_busy0, sm_done0, sm_busy1, sm_done1}), 32'd0);
        check("rst_od_out_zero", 32'(od_out == '0), 32'd1);
        @(negedge clk) reset = 1'b1;

        // Table-driven 2x2 windows: result, latency, and no early output change.
        for (int v = 0; v < 8; v++) begin
            logic [15:0] prev0, prev1;
            int done_edge, hold_err;
            sm_in = {vecs[v].w[3], vecs[v].w[2], vecs[v].w[1], vecs[v].w[0]};
            prev0 = sm_out0;
            prev1 = sm_out1;
            done_edge = -1;
            hold_err  = 0;
            @(negedge clk) sm_start = 1'b1;
            @(posedge clk);
            #1 sm_start = 1'b0;
            for (int e = 1; e <= 50; e++) begin
                @(posedge clk);
                #1;
                if (e < 5 && (sm_out0 !== prev0 || sm_out1 !== prev1)) hold_err++;
                if (e >= 5 && (sm_out0 !== vecs[v].exp_norelu || sm_out1 !== vecs[v].exp_relu)) hold_err++;
                if (sm_done0 === 1'b1) begin
                    done_edge = e;
                    break;
                end
            end
            check($sformatf("vec%0d_norelu", v), 32'(sm_out0), 32'(vecs[v].exp_norelu));
            check($sformatf("vec%0d_relu", v), 32'(sm_out1), 32'(vecs[v].exp_relu));
            check($sformatf("vec%0d_done_edge", v), 32'(done_edge), 32'd6);
            check($sformatf("vec%0d_relu_done_sync", v), 32'({sm_done1, sm_busy0, sm_busy1}), 32'b100);
            check($sformatf("vec%0d_single_update", v), 32'(hold_err), 32'd0);
        end

        // Odd size: last row/column never read.
        begin
            int done_edge;
            done_edge = -1;
            @(negedge clk) od_start = 1'b1;
            @(posedge clk);
            #1 od_start = 1'b0;
            for (int e = 1; e <= 60; e++) begin
                @(posedge clk);
                #1;
                if (od_done === 1'b1) begin
                    done_edge = e;
                    break;
                end
            end
            check("odd_done_edge", 32'(done_edge), 32'd21);
            for (int i = 0; i < 4; i++)
                check($sformatf("odd_out[%0d]", i), 32'(od_out[i*16 +: 16]), 32'd1);
        end

        // Full default pass with stray starts at E100 and E500.
        run_big("ramp", 1'b1, 0);
        check_ramp("ramp");

        // Mid-pass asynchronous reset, then a fresh full pass.
        run_big("abort", 1'b0, 1000);
        run_big("rerun", 1'b0, 0);
        check_ramp("rerun");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/maxpool2d.md
# maxpool2d

Consumes the flat multi-channel feature map produced by the convolution stage and writes a spatially down-sampled map. Each output pixel is the signed maximum over a non-overlapping POOL×POOL window, with an optional fused ReLU. The block is start/done sequenced like the other layer blocks and sits between a convolution layer and the next layer or dense stage. It reads one input element per cycle under its own FSM.

## Interface
- DATA_WIDTH, 16: signed fixed-point word width. The pooling is format-agnostic, so no fractional-bit parameter is needed.
- CHANNELS, 8: number of feature maps, pooled independently.
- IMG_SIZE, 28: input height and width (square).
- POOL, 2: window size and stride. OUT_SIZE = IMG_SIZE/POOL, floor division.
- RELU, 1: when 1, negative window maxima are written as 0.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin one full pass; sampled only in IDLE.
- input_feature_flat  in  DATA_WIDTH signed × CHANNELS*IMG_SIZE*IMG_SIZE  flat input; index (ch*IMG_SIZE+row)*IMG_SIZE+col.
- out_feature_flat  out  DATA_WIDTH signed × CHANNELS*OUT_SIZE*OUT_SIZE  flat output; same index order, with OUT_SIZE in place of IMG_SIZE.
- busy  out  1  high from the cycle after start is accepted through the FINISH cycle.
- done  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: on start, clear the ch/orow/ocol/pr/pc counters and go to SCAN.
  - SCAN: read element (ch, orow*POOL+pr, ocol*POOL+pc).
    - When pr=pc=0, load it into the running max.
    - Otherwise the running max becomes the signed maximum of the running max and the element. On equal values, keep the current max.
    - pc increments first, then pr. After element (POOL-1, POOL-1), go to WRITE.
  - WRITE: compute res = (RELU and max<0) ? 0 : max, and write it to out index (ch*OUT_SIZE+orow)*OUT_SIZE+ocol.
    - Advance ocol, then orow, then ch. Clear pr and pc.
    - Return to SCAN, or go to FINISH after the last window.
  - FINISH: set done<=1 and go to IDLE.
- Comparison is full-width signed. There is no rounding, no saturation and no width growth, so the output word equals an input word or 0.
- When IMG_SIZE is odd, the last row and column are never read.
- start is ignored in SCAN, WRITE and FINISH. start held high through FINISH is re-sampled in the following IDLE cycle.
- The input array must stay stable from start acceptance until done. The block does not latch it.

## Timing
- Reset is asynchronous and active-low, with immediate effect. While it is low:
  - state goes to IDLE;
  - done=0 and busy=0;
  - all counters and the running max are cleared;
  - every out_feature_flat word is cleared to 0.
  Releasing reset mid-pass abandons the pass. A new start is required.
- Window cost is POOL*POOL SCAN cycles plus 1 WRITE cycle. W = CHANNELS*OUT_SIZE*OUT_SIZE.
- Edge E0 samples start. The last WRITE occurs at edge E(W*(POOL*POOL+1)). FINISH executes at edge E(W*(POOL*POOL+1)+1). done is high for exactly the one cycle after that edge.
- Default parameters: W=1568, so done rises at E7841.
- busy rises at E0 and falls at the same edge done rises. busy and done are never both high.
- A given out word updates exactly once per pass, at its WRITE edge. Words not yet written keep their previous values.
- Back-to-back passes: the earliest next start is sampled in the IDLE cycle coinciding with done high.

## Test plan
- Ramp, defaults: input[i] = i mod 2^15. Check out[(c*14+r)*14+k] = input[(c*28+2r+1)*28+2k+1] for every element. Check done at E7841, and busy high E0..E7840.
- Negatives, CHANNELS=1, IMG_SIZE=2, window {-5,-3,-8,-4}:
  - RELU=0 gives out[0] = -3 (0xFFFD).
  - RELU=1 gives out[0] = 0.
  - done arrives 6 edges after start.
- Extremes, RELU=0: window {0x8000,0x8000,0x8000,0x7FFF} gives 0x7FFF. Window of all 0x8000 gives 0x8000. Ties keep the value with no glitch.
- Odd size, IMG_SIZE=5, POOL=2, CHANNELS=1:
  - Row 4 and column 4 are set to 0x7000; all other elements are 1.
  - All 4 outputs are 1.
  - done arrives at edge 4*5+2 = 22, i.e. E21.
- start pulsed again at E100 and E500 of a default pass: no restart, and done still arrives at E7841 only.
- reset driven low asynchronously at E1000 (mid-SCAN) for 3 cycles:
  - done and busy go to 0 immediately, and all outputs read 0.
  - A fresh start then produces a correct full pass with done at E7841 relative to the new E0.
